single_cycle_cpu: RTL and testbench

Single-cycle RV64I-subset processor core: each clock edge fetches, decodes, executes and retires one 32-bit instruction. It contains an internal instruction ROM, register file, ALU and data RAM, and has no external bus. The only observable output is a 64-bit debug port for simulation and bring-up.

---
 rtl/single_cycle_cpu.sv | 105 ++++++++++
 tb/tb_single_cycle_cpu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: single-cycle RV64I-subset core with hardwired ROM, register file and data RAM.
// Every rising edge retires the instruction at pc; debug_out mirrors x10.
module single_cycle_cpu #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_DWORDS = 32,
    parameter logic [IMEM_WORDS*32-1:0] ROM_IMAGE = {
        {(IMEM_WORDS-10){32'h00000013}},
        32'h0000006F, 32'h00150513, 32'hFFF00513, 32'h00250463, 32'h40118533,
        32'h00003183, 32'h00A03023, 32'h00208533, 32'h00700113, 32'h00500093
    }
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] debug_out
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_DWORDS);
    localparam logic [6:0] OP = 7'h33, OP_IMM = 7'h13, LOAD = 7'h03, STORE = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63, JAL = 7'h6F, LUI = 7'h37;
    logic [63:0] pc, next_pc;
    logic [63:0] regs [32];
    logic [63:0] dmem [DMEM_DWORDS];
    logic [31:0] instr;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [63:0] rs1_val, rs2_val, alu_b, alu_y, addr, reg_wd;
    logic [DW-1:0] addr_idx;
    logic        alt, r_ok, i_ok, reg_we, mem_we, eq;
    logic        unused_addr;
    assign instr  = ROM_IMAGE[pc[IW+1:2]*32 +: 32];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];
    assign imm_i  = {{52{instr[31]}}, instr[31:20]};
    assign imm_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];
    assign eq      = rs1_val == rs2_val;
    assign r_ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    assign i_ok = f3 != 3'd1 && f3 != 3'd3 && f3 != 3'd5;
    assign alt   = opcode == OP && f7[5];
    assign alu_b = opcode == OP ? rs2_val : imm_i;
    // Low three address bits are dropped and the upper bits wrap the RAM index.
    assign addr     = rs1_val + (opcode == STORE ? imm_s : imm_i);
    assign addr_idx = addr[DW+2:3];
    assign unused_addr = ^{addr[63:DW+3], addr[2:0]};
    always_comb begin
        case (f3)
            3'd0:    alu_y = alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1:    alu_y = rs1_val << alu_b[5:0];
            3'd2:    alu_y = {63'b0, $signed(rs1_val) < $signed(alu_b)};
            3'd4:    alu_y = rs1_val ^ alu_b;
            3'd5:    alu_y = alt ? 64'($signed(rs1_val) >>> alu_b[5:0]) : rs1_val >> alu_b[5:0];
            3'd6:    alu_y = rs1_val | alu_b;
            3'd7:    alu_y = rs1_val & alu_b;
            default: alu_y = 64'b0;
        endcase
    end
    always_comb begin
        reg_we  = 1'b0;
        reg_wd  = alu_y;
        mem_we  = 1'b0;
        next_pc = pc + 64'd4;
        case (opcode)
            OP:     reg_we = r_ok;
            OP_IMM: reg_we = i_ok;
            LOAD: begin
                reg_we = f3 == 3'd3;
                reg_wd = dmem[addr_idx];
            end
            STORE:  mem_we = f3 == 3'd3;
            BRANCH: next_pc = (f3 == 3'd0 && eq) || (f3 == 3'd1 && !eq) ? pc + imm_b : pc + 64'd4;
            JAL: begin
                reg_we  = 1'b1;
                reg_wd  = pc + 64'd4;
                next_pc = pc + imm_j;
            end
            LUI: begin
                reg_we = 1'b1;
                reg_wd = imm_u;
            end
            default: reg_we = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 64'b0;
            for (int i = 0; i < 32; i++) regs[i] <= 64'b0;
            for (int i = 0; i < DMEM_DWORDS; i++) dmem[i] <= 64'b0;
        end else begin
            pc <= next_pc;
            if (reg_we && rd != 5'd0) regs[rd] <= reg_wd;
            if (mem_we) dmem[addr_idx] <= rs2_val;
        end
    end
    assign debug_out = regs[10];
endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb_single_cycle_cpu: runs the default program and a second ROM image against an
// instruction-level model of both cores, plus hand-computed checkpoints.
module tb_single_cycle_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [63:0] dbg0, dbg1;
    int ncmp = 0;
    int nfail = 0;
    bit armed = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] e_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] m;
        m = imm;
        return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] m;
        m = imm;
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_j(int imm, int rd);
        logic [31:0] m;
        m = imm;
        return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
    endfunction
    function automatic logic [31:0] e_u(int imm, int rd);
        return {20'(imm), 5'(rd), 7'h37};
    endfunction

    function automatic logic [2047:0] prog2();
        logic [2047:0] img;
        for (int i = 0; i < 64; i++) img[i*32 +: 32] = 32'h00000013;
        img[32*0  +: 32] = e_u('h12345, 5);
        img[32*1  +: 32] = e_i(-8, 0, 0, 6, 'h13);
        img[32*2  +: 32] = e_i(2, 0, 0, 1, 'h13);
        img[32*3  +: 32] = e_r('h20, 1, 6, 5, 7);
        img[32*4  +: 32] = e_r(0, 1, 6, 5, 8);
        img[32*5  +: 32] = e_r(0, 1, 5, 1, 9);
        img[32*6  +: 32] = e_r(0, 1, 6, 2, 10);
        img[32*7  +: 32] = e_i(-1, 6, 2, 11, 'h13);
        img[32*8  +: 32] = e_r(0, 6, 5, 4, 12);
        img[32*9  +: 32] = e_r(0, 6, 1, 6, 13);
        img[32*10 +: 32] = e_r(0, 6, 5, 7, 14);
        img[32*11 +: 32] = e_i('hF0, 6, 7, 15, 'h13);
        img[32*12 +: 32] = e_i('h100, 1, 6, 16, 'h13);
        img[32*13 +: 32] = e_i(-1, 6, 4, 17, 'h13);
        img[32*14 +: 32] = 32'hFFFFFFFF;
        img[32*15 +: 32] = e_s('h113, 5, 6, 3);
        img[32*16 +: 32] = e_i(9, 0, 3, 18, 'h03);
        img[32*17 +: 32] = e_b(8, 6, 1, 1);
        img[32*18 +: 32] = e_i(99, 0, 0, 10, 'h13);
        img[32*19 +: 32] = e_b(8, 6, 1, 0);
        img[32*20 +: 32] = e_b(8, 1, 1, 1);
        img[32*21 +: 32] = e_r('h20, 6, 10, 0, 10);
        img[32*22 +: 32] = e_j(8, 19);
        img[32*23 +: 32] = e_i(55, 0, 0, 10, 'h13);
        img[32*24 +: 32] = e_b(8, 0, 0, 0);
        img[32*25 +: 32] = e_i(77, 0, 0, 10, 'h13);
        img[32*26 +: 32] = e_i(1, 20, 0, 20, 'h13);
        img[32*27 +: 32] = e_b(-4, 1, 20, 1);
        img[32*28 +: 32] = e_r(1, 1, 1, 0, 10);
        img[32*29 +: 32] = e_r(0, 1, 1, 0, 0);
        img[32*30 +: 32] = e_j(0, 0);
        return img;
    endfunction
    localparam logic [2047:0] P2 = prog2();

    single_cycle_cpu dut (.clk(clk), .rst(rst), .debug_out(dbg0));
    single_cycle_cpu #(.ROM_IMAGE(P2)) dut2 (.clk(clk), .rst(rst), .debug_out(dbg1));

    logic [31:0] m_rom [2][64];
    logic [63:0] m_x   [2][32];
    logic [63:0] m_mem [2][32];
    logic [63:0] m_pc  [2];
    logic [63:0] d_x   [2][32];
    logic [63:0] d_mem [2][32];
    logic [63:0] d_pc  [2];
    logic [63:0] d_dbg [2];

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_rom[0][i] = 32'h00000013;
            m_rom[1][i] = P2[i*32 +: 32];
        end
        m_rom[0][0] = e_i(5, 0, 0, 1, 'h13);
        m_rom[0][1] = e_i(7, 0, 0, 2, 'h13);
        m_rom[0][2] = e_r(0, 2, 1, 0, 10);
        m_rom[0][3] = e_s(0, 10, 0, 3);
        m_rom[0][4] = e_i(0, 0, 3, 3, 'h03);
        m_rom[0][5] = e_r('h20, 1, 3, 0, 10);
        m_rom[0][6] = e_b(8, 2, 10, 0);
        m_rom[0][7] = e_i(-1, 0, 0, 10, 'h13);
        m_rom[0][8] = e_i(1, 10, 0, 10, 'h13);
        m_rom[0][9] = e_j(0, 0);
    end

    // Instruction-level model: one architectural step per call.
    task automatic m_step(input int c);
        logic [31:0] w;
        logic [63:0] a, b, ii, v, np;
        logic we;
        w  = m_rom[c][m_pc[c][7:2]];
        a  = m_x[c][w[19:15]];
        b  = m_x[c][w[24:20]];
        ii = {{52{w[31]}}, w[31:20]};
        np = m_pc[c] + 64'd4;
        v  = 64'd0;
        we = 1'b0;
        case (w[6:0])
            7'h33: begin
                we = 1'b1;
                case ({w[31:25], w[14:12]})
                    10'h000: v = a + b;
                    10'h100: v = a - b;
                    10'h001: v = a << b[5:0];
                    10'h002: v = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                    10'h004: v = a ^ b;
                    10'h005: v = a >> b[5:0];
                    10'h105: v = 64'($signed(a) >>> b[5:0]);
                    10'h006: v = a | b;
                    10'h007: v = a & b;
                    default: we = 1'b0;
                endcase
            end
            7'h13: begin
                we = 1'b1;
                case (w[14:12])
                    3'd0: v = a + ii;
                    3'd2: v = ($signed(a) < $signed(ii)) ? 64'd1 : 64'd0;
                    3'd4: v = a ^ ii;
                    3'd6: v = a | ii;
                    3'd7: v = a & ii;
                    default: we = 1'b0;
                endcase
            end
            7'h03: if (w[14:12] == 3'd3) begin
                v  = m_mem[c][5'((a + ii) >> 3)];
                we = 1'b1;
            end
            7'h23: if (w[14:12] == 3'd3)
                m_mem[c][5'((a + {{52{w[31]}}, w[31:25], w[11:7]}) >> 3)] = b;
            7'h63: if ((w[14:12] == 3'd0 && a == b) || (w[14:12] == 3'd1 && a != b))
                np = m_pc[c] + {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'h6F: begin
                v  = m_pc[c] + 64'd4;
                we = 1'b1;
                np = m_pc[c] + {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h37: begin
                v  = {{32{w[31]}}, w[31:12], 12'b0};
                we = 1'b1;
            end
            default: we = 1'b0;
        endcase
        if (we && w[11:7] != 5'd0) m_x[c][w[11:7]] = v;
        m_pc[c] = np;
    endtask

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_pc[c] = 64'd0;
                for (int i = 0; i < 32; i++) begin
                    m_x[c][i]   = 64'd0;
                    m_mem[c][i] = 64'd0;
                end
            end else m_step(c);
        end
    end

    task automatic chk(input string nm, input int c, input logic [63:0] got, input logic [63:0] want);
        ncmp++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s core%0d t=%0t: got %h want %h", nm, c, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            d_pc[0] = dut.pc;
            d_pc[1] = dut2.pc;
            d_dbg[0] = dbg0;
            d_dbg[1] = dbg1;
            for (int i = 0; i < 32; i++) begin
                d_x[0][i] = dut.regs[i];
                d_x[1][i] = dut2.regs[i];
                d_mem[0][i] = dut.dmem[i];
                d_mem[1][i] = dut2.dmem[i];
            end
            for (int c = 0; c < 2; c++) begin
                int br, bm;
                br = 0;
                bm = 0;
                for (int i = 31; i >= 0; i--) begin
                    if (d_x[c][i] !== m_x[c][i]) br = i;
                    if (d_mem[c][i] !== m_mem[c][i]) bm = i;
                end
                chk("pc", c, d_pc[c], m_pc[c]);
                chk("debug_out", c, d_dbg[c], m_x[c][10]);
                chk($sformatf("x%0d", br), c, d_x[c][br], m_x[c][br]);
                chk($sformatf("dmem%0d", bm), c, d_mem[c][bm], m_mem[c][bm]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        armed = 1'b1;
        chk("reset_pc", 0, dut.pc, 64'd0);
        chk("reset_debug", 0, dbg0, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_retire_x1", 0, dut.regs[1], 64'd5);
        chk("first_retire_pc", 0, dut.pc, 64'd4);
        repeat (3) @(negedge clk);
        chk("pre_reset_dmem0", 0, dut.dmem[0], 64'd12);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_pc", 0, dut.pc, 64'd0);
        chk("midreset_debug", 0, dbg0, 64'd0);
        chk("midreset_dmem0", 0, dut.dmem[0], 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("add_debug", 0, dbg0, 64'd12);
        chk("model_add", 0, m_x[0][10], 64'd12);
        repeat (2) @(negedge clk);
        chk("ld_x3", 0, dut.regs[3], 64'd12);
        chk("sd_dmem0", 0, dut.dmem[0], 64'd12);
        @(negedge clk);
        chk("sub_debug", 0, dbg0, 64'd7);
        repeat (2) @(negedge clk);
        chk("final_debug", 0, dbg0, 64'd8);
        chk("model_final", 0, m_x[0][10], 64'd8);
        repeat (20) @(negedge clk);
        chk("halt_debug", 0, dbg0, 64'd8);
        chk("halt_pc", 0, dut.pc, 64'h24);
        chk("halt_x0", 0, dut.regs[0], 64'd0);
        repeat (20) @(negedge clk);
        chk("p2_pc", 1, dut2.pc, 64'd120);
        chk("p2_debug", 1, dbg1, 64'd9);
        chk("p2_model_debug", 1, m_x[1][10], 64'd9);
        chk("p2_sra", 1, dut2.regs[7], 64'hFFFFFFFFFFFFFFFE);
        chk("p2_srl", 1, dut2.regs[8], 64'h3FFFFFFFFFFFFFFE);
        chk("p2_sll", 1, dut2.regs[9], 64'h48D14000);
        chk("p2_slti", 1, dut2.regs[11], 64'd1);
        chk("p2_xor", 1, dut2.regs[12], 64'hFFFFFFFFEDCBAFF8);
        chk("p2_or", 1, dut2.regs[13], 64'hFFFFFFFFFFFFFFFA);
        chk("p2_and", 1, dut2.regs[14], 64'h12345000);
        chk("p2_andi", 1, dut2.regs[15], 64'hF0);
        chk("p2_ori", 1, dut2.regs[16], 64'h102);
        chk("p2_xori", 1, dut2.regs[17], 64'd7);
        chk("p2_ld_wrap", 1, dut2.regs[18], 64'h12345000);
        chk("p2_sd_wrap", 1, dut2.dmem[1], 64'h12345000);
        chk("p2_jal_link", 1, dut2.regs[19], 64'd92);
        chk("p2_loop", 1, dut2.regs[20], 64'd2);
        chk("p2_x0", 1, dut2.regs[0], 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
